crossbar_scheduler: RTL and testbench
=====================================

// Module: crossbar_scheduler
// PURPOSE
//  Sequences the 3x3 switch datapath: inspects the head word of each input Fifo (show-ahead), grants each
//  output port to one input per packet by round-robin, drives megamux selects and Fifo rdreq for the packet's
//  length, and drains packets with illegal destinations. Sits between the Fifo bank and the output megamuxes.
// PARAMETERS
//  N_PORTS   3   number of inputs = number of outputs (mux_sel value 0 = idle/zero source)
//  DATA_W    32  Fifo word width
//  LEN_W     10  packet length field width (words, header included)
// PORTS
//  clk           in   1               system clock
//  reset         in   1               asynchronous, active-low reset
//  sched_en      in   1               1 = new grants allowed; 0 = finish in-flight packets only
//  fifo_empty    in   N_PORTS         per-input Fifo empty
//  fifo_head     in   N_PORTS*DATA_W  per-input Fifo q (valid when !empty)
//  fifo_rd       out  N_PORTS         per-input Fifo rdreq (one word popped per asserted cycle)
//  mux_sel       out  N_PORTS*2       per-output megamux select: 0 idle, i+1 = input i
//  out_valid     out  N_PORTS         per-output: megamux result is a packet word this cycle
//  out_sop       out  N_PORTS         per-output: header word this cycle
//  out_eop       out  N_PORTS         per-output: last word this cycle
//  stat_sel      in   3               stats select (SCHED_STATS_EN only)
//  stat_data     out  16              stats read data (SCHED_STATS_EN only, else 0)
// BEHAVIOUR
//  - Header = head word when input idle: dest=[1:0] (1..N_PORTS valid, 0 or >N_PORTS illegal), len=[LEN_W+1:2];
//    len 0 treated as 1.
//  - Input busy from grant/drop start until its eop. Each input requests exactly one output -> no input conflicts.
//  - Per output FSM IDLE/XFER. IDLE, cycle t: candidates = inputs !empty, !busy, dest==o+1; if sched_en and any,
//    winner = first candidate at or after rr_ptr[o] (wrapping). t+1: state XFER, mux_sel=winner+1, remaining=len.
//  - XFER: fifo_rd[i]=out_valid[o]=!fifo_empty[i] (combinational from registered state). Empty mid-packet = stall:
//    grant held, no pop, no valid. out_sop on first transferred word; out_eop when remaining==1 and word moves.
//    On eop: IDLE next cycle, rr_ptr[o]=winner+1 mod N_PORTS, mux_sel=0. One idle cycle between packets per output.
//  - Illegal dest, input idle and !empty, sched_en=1: enter DROP at t+1, pop len words (stalling on empty),
//    no output valid; drop_cnt[i]++ at end. Drop does not consume an output grant.
//  - sched_en falling mid-packet: packet completes normally; no new grant/drop starts while low.
//  - remaining is LEN_W bits, decrements only on a transferred word; never wraps below 1.
//  - Reset (async, any time): all FSMs IDLE, mux_sel=0, rr_ptr=0, fifo_rd/out_valid/sop/eop=0, counters=0.
//    Partial packets abandoned; Fifos are NOT flushed — software must reset Fifos alongside.
//  - Latency: header at head on cycle t -> header on output valid at t+1 (if Fifo non-empty).
// CONFIGURATION
//  SCHED_STATS_EN defined: 16-bit saturating counters: stat_sel 0..2 = packets forwarded per output,
//  3..5 = packets dropped per input, 6..7 read 0; stat_data registered (1-cycle latency).
//  Undefined: no counters, stat_data tied 0, stat_sel ignored.
// STRUCTURE
//  switch_pkg: N_PORTS, DATA_W, LEN_W, header field offsets (DEST_LSB/MSB, LEN_LSB/MSB), typedef port_sel_t,
//  typedef enum sched_state_e {IDLE, XFER, DROP}.
//  Sub-module rr_arbiter (N-bit req, ptr -> one-hot grant + valid), one instance per output.
// TESTING
//  1 Input0 header dest=2 len=4, 4 words present -> t+1 mux_sel[1]=1, out_valid[1] 4 cycles, sop c1, eop c4, fifo_rd[0] x4.
//  2 Inputs 0,1,2 all dest=1 len=2, repeated -> output0 grants 0,1,2,0... with one idle cycle between packets.
//  3 Input1 dest=3 len=5, Fifo empties after word 2 for 3 cycles -> grant held, no valid/rd during gap, eop on word 5.
//  4 Input2 dest=0 len=3 -> 3 pops, no out_valid anywhere, drop_cnt[2]=1 (stats build: stat_sel=5 reads 1).
//  5 sched_en=0 during packet len=6 -> completes; pending header waits, granted 1 cycle after sched_en=1.
//  6 reset asserted mid-XFER -> same cycle all outputs 0, mux_sel=0; after release rr_ptr=0, FSMs IDLE.

Source files
------------

// File: rtl/crossbar_scheduler_pkg.sv
// rtl/crossbar_scheduler_pkg.sv - shared parameters, header field layout and types for the 3x3 switch scheduler
package crossbar_scheduler_pkg;

  localparam int N_PORTS  = 3;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 10;
  localparam int DEST_LSB = 0;
  localparam int DEST_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = LEN_W + 1;

  typedef logic [1:0]       port_sel_t;
  typedef logic [LEN_W-1:0] pkt_len_t;

  typedef enum logic [1:0] {IDLE, XFER, DROP} sched_state_e;

  function automatic port_sel_t next_port(port_sel_t p);
    return (p == port_sel_t'(N_PORTS - 1)) ? port_sel_t'(0) : p + 2'd1;
  endfunction

  // A zero length field still carries the header word itself.
  function automatic pkt_len_t hdr_len(pkt_len_t l);
    return (l == '0) ? pkt_len_t'(1) : l;
  endfunction

  function automatic port_sel_t onehot_idx(logic [N_PORTS-1:0] oh);
    port_sel_t idx;
    idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (oh[i]) idx = port_sel_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/crossbar_scheduler_if.sv
// rtl/crossbar_scheduler_if.sv - Fifo-bank and megamux signals between the scheduler and the switch datapath
interface crossbar_scheduler_if;
  import crossbar_scheduler_pkg::*;

  logic [N_PORTS-1:0]        fifo_empty;
  logic [N_PORTS*DATA_W-1:0] fifo_head;
  logic [N_PORTS-1:0]        fifo_rd;
  logic [N_PORTS*2-1:0]      mux_sel;
  logic [N_PORTS-1:0]        out_valid;
  logic [N_PORTS-1:0]        out_sop;
  logic [N_PORTS-1:0]        out_eop;

  modport master (
    input  fifo_empty, fifo_head,
    output fifo_rd, mux_sel, out_valid, out_sop, out_eop
  );

  modport slave (
    output fifo_empty, fifo_head,
    input  fifo_rd, mux_sel, out_valid, out_sop, out_eop
  );

endinterface

// File: rtl/crossbar_scheduler_rr_arbiter.sv
// rtl/crossbar_scheduler_rr_arbiter.sv - round-robin pick of the first requester at or after ptr
module rr_arbiter
  import crossbar_scheduler_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  port_sel_t          ptr,
  output logic [N_PORTS-1:0] grant,
  output logic               valid
);

  logic      found;
  port_sel_t idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = port_sel_t'((int'(ptr) + k) % N_PORTS);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/crossbar_scheduler.sv
// rtl/crossbar_scheduler.sv - per-output round-robin packet grants, megamux selects, Fifo pops and illegal-dest drops
// Optional SCHED_STATS_EN adds saturating forwarded/dropped packet counters readable via stat_sel/stat_data.
module crossbar_scheduler
  import crossbar_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sched_en,
  crossbar_scheduler_if.master sw,
  input  logic [2:0]           stat_sel,
  output logic [15:0]          stat_data
);

  port_sel_t          dest_w [N_PORTS];
  pkt_len_t           len_w  [N_PORTS];
  logic [N_PORTS-1:0] legal_w;
  logic [N_PORTS-1:0] busy_w;
  logic [N_PORTS-1:0] req_w  [N_PORTS];
  logic [N_PORTS-1:0] gnt_w  [N_PORTS];
  logic [N_PORTS-1:0] gnt_valid_w;
  logic [N_PORTS-1:0] fwd_done_w;
  logic [N_PORTS-1:0] drop_done_w;
  logic               unused_head;

  sched_state_e       out_state_q [N_PORTS], out_state_d [N_PORTS];
  port_sel_t          winner_q    [N_PORTS], winner_d    [N_PORTS];
  port_sel_t          rr_ptr_q    [N_PORTS], rr_ptr_d    [N_PORTS];
  pkt_len_t           out_rem_q   [N_PORTS], out_rem_d   [N_PORTS];
  logic [N_PORTS-1:0] sop_pend_q, sop_pend_d;
  sched_state_e       in_state_q  [N_PORTS], in_state_d  [N_PORTS];
  pkt_len_t           drop_rem_q  [N_PORTS], drop_rem_d  [N_PORTS];

  assign unused_head = ^sw.fifo_head;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      dest_w[i]  = sw.fifo_head[i*DATA_W + DEST_LSB +: 2];
      len_w[i]   = hdr_len(sw.fifo_head[i*DATA_W + LEN_LSB +: LEN_W]);
      legal_w[i] = (dest_w[i] != '0) && (dest_w[i] <= port_sel_t'(N_PORTS));
    end
  end

  // An input is busy while granted to an output or being drained.
  always_comb begin
    busy_w = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      busy_w[i] = (in_state_q[i] == DROP);
    end
    for (int o = 0; o < N_PORTS; o++) begin
      if (out_state_q[o] == XFER) busy_w[winner_q[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        req_w[o][i] = sched_en && !sw.fifo_empty[i] && !busy_w[i] &&
                      (dest_w[i] == port_sel_t'(o + 1));
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
    rr_arbiter u_arb (
      .req   (req_w[g]),
      .ptr   (rr_ptr_q[g]),
      .grant (gnt_w[g]),
      .valid (gnt_valid_w[g])
    );
  end

  always_comb begin
    sw.fifo_rd   = '0;
    sw.mux_sel   = '0;
    sw.out_valid = '0;
    sw.out_sop   = '0;
    sw.out_eop   = '0;
    fwd_done_w   = '0;
    drop_done_w  = '0;
    sop_pend_d   = sop_pend_q;
    for (int o = 0; o < N_PORTS; o++) begin
      out_state_d[o] = out_state_q[o];
      winner_d[o]    = winner_q[o];
      rr_ptr_d[o]    = rr_ptr_q[o];
      out_rem_d[o]   = out_rem_q[o];
      case (out_state_q[o])
        IDLE: begin
          if (gnt_valid_w[o]) begin
            out_state_d[o] = XFER;
            winner_d[o]    = onehot_idx(gnt_w[o]);
            out_rem_d[o]   = len_w[onehot_idx(gnt_w[o])];
            sop_pend_d[o]  = 1'b1;
          end
        end
        XFER: begin
          sw.mux_sel[o*2 +: 2] = winner_q[o] + 2'd1;
          // An empty Fifo mid-packet stalls the transfer without releasing the grant.
          if (!sw.fifo_empty[winner_q[o]]) begin
            sw.fifo_rd[winner_q[o]] = 1'b1;
            sw.out_valid[o]         = 1'b1;
            sw.out_sop[o]           = sop_pend_q[o];
            sop_pend_d[o]           = 1'b0;
            if (out_rem_q[o] <= pkt_len_t'(1)) begin
              sw.out_eop[o]  = 1'b1;
              fwd_done_w[o]  = 1'b1;
              out_state_d[o] = IDLE;
              rr_ptr_d[o]    = next_port(winner_q[o]);
            end else begin
              out_rem_d[o] = out_rem_q[o] - pkt_len_t'(1);
            end
          end
        end
        default: out_state_d[o] = IDLE;
      endcase
    end
    for (int i = 0; i < N_PORTS; i++) begin
      in_state_d[i] = in_state_q[i];
      drop_rem_d[i] = drop_rem_q[i];
      if (in_state_q[i] == DROP) begin
        if (!sw.fifo_empty[i]) begin
          sw.fifo_rd[i] = 1'b1;
          if (drop_rem_q[i] <= pkt_len_t'(1)) begin
            in_state_d[i]  = IDLE;
            drop_done_w[i] = 1'b1;
          end else begin
            drop_rem_d[i] = drop_rem_q[i] - pkt_len_t'(1);
          end
        end
      end else if (sched_en && !busy_w[i] && !sw.fifo_empty[i] && !legal_w[i]) begin
        in_state_d[i] = DROP;
        drop_rem_d[i] = len_w[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_PORTS; k++) begin
        out_state_q[k] <= IDLE;
        winner_q[k]    <= '0;
        rr_ptr_q[k]    <= '0;
        out_rem_q[k]   <= '0;
        in_state_q[k]  <= IDLE;
        drop_rem_q[k]  <= '0;
      end
      sop_pend_q <= '0;
    end else begin
      out_state_q <= out_state_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      out_rem_q   <= out_rem_d;
      in_state_q  <= in_state_d;
      drop_rem_q  <= drop_rem_d;
      sop_pend_q  <= sop_pend_d;
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] fwd_cnt_q  [N_PORTS], fwd_cnt_d  [N_PORTS];
  logic [15:0] drop_cnt_q [N_PORTS], drop_cnt_d [N_PORTS];
  logic [15:0] stat_data_q, stat_data_d;

  always_comb begin
    for (int k = 0; k < N_PORTS; k++) begin
      fwd_cnt_d[k]  = fwd_cnt_q[k] +
                      ((fwd_done_w[k] && fwd_cnt_q[k] != 16'hFFFF) ? 16'd1 : 16'd0);
      drop_cnt_d[k] = drop_cnt_q[k] +
                      ((drop_done_w[k] && drop_cnt_q[k] != 16'hFFFF) ? 16'd1 : 16'd0);
    end
    case (stat_sel)
      3'd0:    stat_data_d = fwd_cnt_q[0];
      3'd1:    stat_data_d = fwd_cnt_q[1];
      3'd2:    stat_data_d = fwd_cnt_q[2];
      3'd3:    stat_data_d = drop_cnt_q[0];
      3'd4:    stat_data_d = drop_cnt_q[1];
      3'd5:    stat_data_d = drop_cnt_q[2];
      default: stat_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_PORTS; k++) begin
        fwd_cnt_q[k]  <= '0;
        drop_cnt_q[k] <= '0;
      end
      stat_data_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      stat_data_q <= stat_data_d;
    end
  end

  assign stat_data = stat_data_q;
`else
  logic unused_stats;
  assign unused_stats = ^{stat_sel, fwd_done_w, drop_done_w};
  assign stat_data    = '0;
`endif

endmodule

// File: tb/tb_crossbar_scheduler.sv
// tb/tb_crossbar_scheduler.sv - directed self-checking bench for crossbar_scheduler with a queue-based Fifo bank
module tb_crossbar_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        sched_en;
  logic [2:0]  stat_sel;
  logic [15:0] stat_data;
  logic [2:0]  gap;
  logic [31:0] fq [3][$];
  int          n_cmp = 0;
  int          n_bad = 0;

  crossbar_scheduler_if sw_if ();

  crossbar_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .sched_en  (sched_en),
    .sw        (sw_if),
    .stat_sel  (stat_sel),
    .stat_data (stat_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hdr(int dest, int len);
    return 32'((len << 2) | dest);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [5:0] mux, logic [2:0] vld, logic [2:0] sop,
                         logic [2:0] eop, logic [2:0] rd);
    chk({tag, ".mux_sel"},   32'(sw_if.mux_sel),   32'(mux));
    chk({tag, ".out_valid"}, 32'(sw_if.out_valid), 32'(vld));
    chk({tag, ".out_sop"},   32'(sw_if.out_sop),   32'(sop));
    chk({tag, ".out_eop"},   32'(sw_if.out_eop),   32'(eop));
    chk({tag, ".fifo_rd"},   32'(sw_if.fifo_rd),   32'(rd));
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      sw_if.fifo_empty[i] = (fq[i].size() == 0) || gap[i];
      sw_if.fifo_head[i*32 +: 32] = (fq[i].size() != 0) ? fq[i][0] : 32'h0;
    end
  endtask

  task automatic cyc();
    logic [2:0] rd;
    rd = sw_if.fifo_rd;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    end
    @(negedge clk);
    drive();
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    sched_en = 1'b1;
    stat_sel = 3'd0;
    gap      = 3'b000;
    drive();
    #12;
    chk_out("reset", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // 1: input0 -> output1, len 4
    fq[0].push_back(hdr(2, 4));
    for (int k = 1; k < 4; k++) fq[0].push_back(32'hA000_0000 | 32'(k));
    drive();
    #1;
    chk_out("t1.idle", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_out($sformatf("t1.w%0d", k), 6'h04, 3'b010, (k == 0) ? 3'b010 : 3'b000,
              (k == 3) ? 3'b010 : 3'b000, 3'b001);
    end
    cyc();
    chk_out("t1.done", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);

    // 2: three inputs contend for output0, round-robin with one idle cycle between packets
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        fq[i].push_back(hdr(1, 2));
        fq[i].push_back(32'hB000_0000 | 32'(i * 16 + p));
      end
    end
    drive();
    #1;
    for (int p = 0; p < 6; p++) begin
      cyc();
      chk_out($sformatf("t2.p%0d.w0", p), 6'(p % 3 + 1), 3'b001, 3'b001, 3'b000, 3'(1 << (p % 3)));
      cyc();
      chk_out($sformatf("t2.p%0d.w1", p), 6'(p % 3 + 1), 3'b001, 3'b000, 3'b001, 3'(1 << (p % 3)));
      cyc();
      chk_out($sformatf("t2.p%0d.gap", p), 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    end

    // 3: input1 -> output2 len 5, Fifo empty for 3 cycles after word 2
    fq[1].push_back(hdr(3, 5));
    for (int k = 1; k < 5; k++) fq[1].push_back(32'hC000_0000 | 32'(k));
    drive();
    #1;
    cyc();
    chk_out("t3.w0", 6'h20, 3'b100, 3'b100, 3'b000, 3'b010);
    cyc();
    chk_out("t3.w1", 6'h20, 3'b100, 3'b000, 3'b000, 3'b010);
    gap = 3'b010;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_out($sformatf("t3.stall%0d", k), 6'h20, 3'b000, 3'b000, 3'b000, 3'b000);
    end
    gap = 3'b000;
    for (int k = 2; k < 5; k++) begin
      cyc();
      chk_out($sformatf("t3.w%0d", k), 6'h20, 3'b100, 3'b000, (k == 4) ? 3'b100 : 3'b000, 3'b010);
    end
    cyc();
    chk_out("t3.done", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);

    // 4: input2 illegal dest 0, len 3 -> drained with no output activity
    fq[2].push_back(hdr(0, 3));
    fq[2].push_back(32'hD000_0001);
    fq[2].push_back(32'hD000_0002);
    drive();
    #1;
    chk_out("t4.idle", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_out($sformatf("t4.drop%0d", k), 6'h00, 3'b000, 3'b000, 3'b000, 3'b100);
    end
    cyc();
    chk_out("t4.done", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    chk("t4.fifo2_left", 32'(fq[2].size()), 32'd0);
`ifdef SCHED_STATS_EN
    stat_sel = 3'd5;
    cyc();
    chk("t4.stat_drop2", 32'(stat_data), 32'd1);
    stat_sel = 3'd0;
    cyc();
    chk("t4.stat_fwd0", 32'(stat_data), 32'd6);
`else
    stat_sel = 3'd5;
    cyc();
    chk("t4.stat_off", 32'(stat_data), 32'd0);
    stat_sel = 3'd0;
`endif

    // 5: sched_en drops mid-packet; pending header waits until re-enable
    fq[0].push_back(hdr(2, 6));
    for (int k = 1; k < 6; k++) fq[0].push_back(32'hE000_0000 | 32'(k));
    drive();
    #1;
    cyc();
    chk_out("t5.w0", 6'h04, 3'b010, 3'b010, 3'b000, 3'b001);
    sched_en = 1'b0;
    fq[2].push_back(hdr(2, 2));
    fq[2].push_back(32'hE100_0001);
    drive();
    #1;
    for (int k = 1; k < 6; k++) begin
      cyc();
      chk_out($sformatf("t5.w%0d", k), 6'h04, 3'b010, 3'b000, (k == 5) ? 3'b010 : 3'b000, 3'b001);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_out($sformatf("t5.hold%0d", k), 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    end
    sched_en = 1'b1;
    cyc();
    chk_out("t5.p2.w0", 6'h0C, 3'b010, 3'b010, 3'b000, 3'b100);
    cyc();
    chk_out("t5.p2.w1", 6'h0C, 3'b010, 3'b000, 3'b010, 3'b100);
    cyc();
    chk_out("t5.done", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);

    // 6: reset mid-transfer on output2, then rr_ptr[2] must be back at 0
    fq[0].push_back(hdr(3, 4));
    for (int k = 1; k < 4; k++) fq[0].push_back(32'hF000_0000 | 32'(k));
    drive();
    #1;
    cyc();
    chk_out("t6.w0", 6'h10, 3'b100, 3'b100, 3'b000, 3'b001);
    cyc();
    chk_out("t6.w1", 6'h10, 3'b100, 3'b000, 3'b000, 3'b001);
    reset = 1'b0;
    #1;
    chk_out("t6.in_reset", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    cyc();
    chk_out("t6.held", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    fq[0].delete();
    reset = 1'b1;
    fq[1].push_back(hdr(3, 1));
    fq[2].push_back(hdr(3, 1));
    drive();
    #1;
    chk_out("t6.idle", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    cyc();
    chk_out("t6.in1", 6'h20, 3'b100, 3'b100, 3'b100, 3'b010);
    cyc();
    chk_out("t6.gap", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);
    cyc();
    chk_out("t6.in2", 6'h30, 3'b100, 3'b100, 3'b100, 3'b100);
    cyc();
    chk_out("t6.done", 6'h00, 3'b000, 3'b000, 3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
